// File: rtl/ipf_pkg.sv
// Shared types for the LCU stream source: parameter-word layout, FSM states and frame geometry.
package ipf_pkg;

  localparam int IMG_LOG = 7;
  localparam int LCU_PIX = 256;
  localparam int N_LCU   = 64;

  typedef struct packed {
    logic [1:0]  typ;
    logic [4:0]  band_pos;
    logic        wo_class;
    logic [15:0] offset;
  } ipf_param_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREF,
    S_RUN,
    S_DRAIN,
    S_DONE
  } lcu_state_e;

endpackage

// File: rtl/lcu_addr_gen.sv
// Issue counter for the LCU-order scan; derives the raster image address and the LCU index.
module lcu_addr_gen #(
  parameter int LCU_LOG  = 4,
  parameter int GRID_LOG = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clr_i,
  input  logic                            adv_i,
  output logic [2*(LCU_LOG+GRID_LOG)-1:0] mem_addr_o,
  output logic [2*GRID_LOG-1:0]           lcu_idx_o,
  output logic                            pix_first_o,
  output logic                            pix_last_o,
  output logic                            frame_last_o
);

  localparam int AW = 2 * (LCU_LOG + GRID_LOG);
  localparam int PW = 2 * LCU_LOG;

  logic [AW-1:0]       cnt_q, cnt_d;
  logic [LCU_LOG-1:0]  col, row;
  logic [GRID_LOG-1:0] lx, ly;

  // Counter runs {lcu_y, lcu_x, row, col}; the ROM wants {lcu_y, row, lcu_x, col}.
  assign col = cnt_q[LCU_LOG-1:0];
  assign row = cnt_q[PW-1:LCU_LOG];
  assign lx  = cnt_q[PW+GRID_LOG-1:PW];
  assign ly  = cnt_q[AW-1:PW+GRID_LOG];

  assign mem_addr_o   = {ly, row, lx, col};
  assign lcu_idx_o    = {ly, lx};
  assign pix_first_o  = (cnt_q[PW-1:0] == '0);
  assign pix_last_o   = &cnt_q[PW-1:0];
  assign frame_last_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (adv_i) cnt_d = cnt_q + AW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcu_stream_src.sv
// Pixel-stream source for the IPF: LCU-order scan of the image ROM with per-LCU side-band.
// Optional build macro LCU_STREAM_CKSUM_EN adds the cksum_o running sum of presented pixels.
//   state   | meaning
//   S_IDLE  | wait for start_i
//   S_PREF  | fetch LCU 0 parameters (read cycle, then load cycle)
//   S_RUN   | one image read per unstalled cycle
//   S_DRAIN | last read issued, wait for it to leave the output stage
//   S_DONE  | one-cycle done_o pulse
module lcu_stream_src
  import ipf_pkg::*;
#(
  parameter int LCU_LOG  = 4,
  parameter int GRID_LOG = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic                            busy_i,
  output logic [2*(LCU_LOG+GRID_LOG)-1:0] mem_addr_o,
  output logic                            mem_rd_o,
  input  logic [7:0]                      mem_rdata_i,
  output logic [2*GRID_LOG-1:0]           param_addr_o,
  output logic                            param_rd_o,
  input  logic [23:0]                     param_rdata_i,
  output logic                            in_en_o,
  output logic [7:0]                      din_o,
  output logic [1:0]                      ipf_type_o,
  output logic [4:0]                      ipf_band_pos_o,
  output logic                            ipf_wo_class_o,
  output logic [15:0]                     ipf_offset_o,
  output logic [GRID_LOG-1:0]             lcu_x_o,
  output logic [GRID_LOG-1:0]             lcu_y_o,
  output logic [1:0]                      lcu_size_o,
  output logic                            done_o
`ifdef LCU_STREAM_CKSUM_EN
  ,
  output logic [15:0]                     cksum_o
`endif
);

  localparam int GW = 2 * GRID_LOG;

  lcu_state_e     state_q, state_d;
  logic           pref_wait_q, pref_wait_d;
  logic           v1_q, v1_d;
  logic           sb_pend_q, sb_pend_d;
  logic           in_en_q, in_en_d;
  logic [7:0]     din_q, din_d;
  ipf_param_t     side_q, side_d, nxt_q, nxt_d;
  logic [GW-1:0]  side_idx_q, side_idx_d, nxt_idx_q, nxt_idx_d;
  logic           pcap_q, pcap_d;

  logic           issue, lookahead, pix_first, pix_last, frame_last;
  logic [GW-1:0]  lcu_idx, nxt_lcu;

  assign issue     = (state_q == S_RUN) && !busy_i;
  assign nxt_lcu   = lcu_idx + GW'(1);
  assign lookahead = issue && pix_first && !(&lcu_idx);

  lcu_addr_gen #(
    .LCU_LOG  (LCU_LOG),
    .GRID_LOG (GRID_LOG)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clr_i        ((state_q == S_IDLE) && start_i),
    .adv_i        (issue),
    .mem_addr_o   (mem_addr_o),
    .lcu_idx_o    (lcu_idx),
    .pix_first_o  (pix_first),
    .pix_last_o   (pix_last),
    .frame_last_o (frame_last)
  );

  always_comb begin
    state_d      = state_q;
    pref_wait_d  = 1'b0;
    v1_d         = v1_q;
    sb_pend_d    = sb_pend_q;
    in_en_d      = 1'b0;
    din_d        = din_q;
    side_d       = side_q;
    side_idx_d   = side_idx_q;
    nxt_d        = nxt_q;
    nxt_idx_d    = nxt_idx_q;
    pcap_d       = lookahead;
    param_rd_o   = 1'b0;
    param_addr_o = '0;

    case (state_q)
      S_IDLE: if (start_i) state_d = S_PREF;
      S_PREF: begin
        pref_wait_d = !pref_wait_q;
        if (!pref_wait_q) begin
          param_rd_o = 1'b1;
        end else begin
          side_d     = ipf_param_t'(param_rdata_i);
          side_idx_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (lookahead) begin
          param_rd_o   = 1'b1;
          param_addr_o = nxt_lcu;
        end
        if (issue && frame_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (!v1_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Side-band switches with the last pixel of an LCU, except after the final LCU.
    if (!busy_i) begin
      din_d     = mem_rdata_i;
      in_en_d   = v1_q;
      v1_d      = issue;
      sb_pend_d = issue && pix_last && !(&lcu_idx);
      if (sb_pend_q) begin
        side_d     = nxt_q;
        side_idx_d = nxt_idx_q;
      end
    end
    if (lookahead) nxt_idx_d = nxt_lcu;
    if (pcap_q)    nxt_d     = ipf_param_t'(param_rdata_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      pref_wait_q <= 1'b0;
      v1_q        <= 1'b0;
      sb_pend_q   <= 1'b0;
      in_en_q     <= 1'b0;
      din_q       <= '0;
      side_q      <= '0;
      side_idx_q  <= '0;
      nxt_q       <= '0;
      nxt_idx_q   <= '0;
      pcap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pref_wait_q <= pref_wait_d;
      v1_q        <= v1_d;
      sb_pend_q   <= sb_pend_d;
      in_en_q     <= in_en_d;
      din_q       <= din_d;
      side_q      <= side_d;
      side_idx_q  <= side_idx_d;
      nxt_q       <= nxt_d;
      nxt_idx_q   <= nxt_idx_d;
      pcap_q      <= pcap_d;
    end
  end

  assign mem_rd_o       = issue;
  assign in_en_o        = in_en_q;
  assign din_o          = din_q;
  assign ipf_type_o     = side_q.typ;
  assign ipf_band_pos_o = side_q.band_pos;
  assign ipf_wo_class_o = side_q.wo_class;
  assign ipf_offset_o   = side_q.offset;
  assign lcu_x_o        = side_idx_q[GRID_LOG-1:0];
  assign lcu_y_o        = side_idx_q[GW-1:GRID_LOG];
  assign lcu_size_o     = 2'd0;
  assign done_o         = (state_q == S_DONE);

`ifdef LCU_STREAM_CKSUM_EN
  logic [15:0] cksum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                          cksum_q <= '0;
    else if ((state_q == S_IDLE) && start_i) cksum_q <= '0;
    else if (in_en_q)                      cksum_q <= cksum_q + {8'd0, din_q};
  end

  assign cksum_o = cksum_q;
`endif

endmodule

// File: doc/lcu_stream_src.md
# lcu_stream_src

Pixel-stream transmitter that feeds the image processing filter. It reads a 128x128 8-bit frame from a synchronous image ROM and per-LCU filter parameters from a parameter ROM. It then presents pixels on `din`/`in_en` in LCU order (LCU raster, then pixel raster inside each 16x16 LCU), together with the per-LCU `ipf_*`/`lcu_*` side-band. It honours the filter's `busy` back-pressure and is the source end of the filter's input interface.

## Interface
- `LCU_LOG`, default 4: log2 of the LCU edge in pixels (16).
- `GRID_LOG`, default 3: log2 of the number of LCUs per image edge (8).
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts one frame; accepted only in IDLE.
- `busy`  in  1  filter back-pressure; stall while high.
- `mem_addr`  out  14  image ROM address `{lcu_y,row,lcu_x,col}` (raster address).
- `mem_rd`  out  1  image ROM read enable. When low, the ROM holds its output.
- `mem_rdata`  in  8  image ROM data, valid the cycle after the `mem_rd` cycle.
- `param_addr`  out  6  parameter ROM address `{lcu_y,lcu_x}`.
- `param_rd`  out  1  parameter ROM read enable.
- `param_rdata`  in  24  parameter word, 1-cycle latency: [23:22] type, [21:17] band_pos, [16] wo_class, [15:0] offset.
- `in_en`  out  1  `din` valid.
- `din`  out  8  pixel.
- `ipf_type`  out  2  per-LCU parameter.
- `ipf_band_pos`  out  5  per-LCU parameter.
- `ipf_wo_class`  out  1  per-LCU parameter.
- `ipf_offset`  out  16  per-LCU parameter.
- `lcu_x`  out  3  current LCU column.
- `lcu_y`  out  3  current LCU row.
- `lcu_size`  out  2  constant 2'd0 (16x16).
- `done`  out  1  one-cycle pulse when the last pixel has been presented.

## Operation
- FSM states: IDLE, PREF, RUN, DRAIN, DONE.
- IDLE: waits for `start`. If `start`=1, go to PREF.
- PREF: `param_rd`=1 with `param_addr`=0. Next cycle, load the side-band outputs from `param_rdata`, then go to RUN.
- RUN: each advancing cycle (`busy`=0) issues one image read and increments a 14-bit issue counter in order {lcu_y, lcu_x, row, col} (col fastest).
  - The cycle that issues pixel 255 of LCU 63 goes to DRAIN.
- Output stage, on each advancing edge: `din`<=`mem_rdata`, `in_en`<=`v1`.
  - `v1` is set to 1 on an advancing edge that issues a read, and cleared otherwise.
- Stall (`busy`=1 at an edge):
  - Issue counter, `v1` and `din` hold.
  - `mem_rd`=0 and `in_en`<=0.
  - The pending pixel is delivered on the first edge after `busy` falls: no loss, no duplication.
- Parameter lookahead:
  - When issuing pixel 0 of LCU k (k<63), assert `param_rd` with `param_addr`=k+1.
  - Capture `param_rdata` into a next-parameter register one cycle later.
  - Side-band outputs, including `lcu_x`/`lcu_y`, load the next-parameter register on the same edge that `din` loads pixel 255 of LCU k. They hold until the next such edge. This matches the filter, which latches parameters at its end-of-LCU.
- DRAIN: continues until the output stage has presented pixel 255 of LCU 63, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. Side-band outputs hold their last values.
- `start` is ignored outside IDLE.
- Reset mid-frame: all state is discarded, FSM goes to IDLE.

## Timing
- Reset values: `in_en`, `din`, `mem_rd`, `mem_addr`, `param_rd`, `param_addr`, all side-band outputs, `lcu_size` and `done` are all 0. FSM is in IDLE.
- Latency: `start` to first `in_en` = 4 cycles when `busy`=0.
- Throughput: one pixel per cycle when unstalled.
- Frame: 16384 `in_en` cycles in total. `done` is asserted 1 cycle after the last `in_en`.
- `busy` is sampled only at the clock edge. It may toggle every cycle.
- Address and counter arithmetic is unsigned and wraps naturally. No overflow handling is needed.

## Configuration
- `LCU_STREAM_CKSUM_EN` defined:
  - Adds output `cksum` (16 bits): modulo-2^16 sum of every `din` presented with `in_en`=1.
  - Cleared on `start`; valid and held from the `done` pulse onward; reset value 0.
- Not defined: port and logic are absent. All other behaviour is identical.

## Structure
- Shared package `ipf_pkg`:
  - `ipf_param_t` struct matching the `param_rdata` layout.
  - FSM state enum.
  - Constants `IMG_LOG`=7, `LCU_PIX`=256, `N_LCU`=64.
- Sub-module `lcu_addr_gen`: issue counter plus `mem_addr`/LCU-index generation, with an advance enable input. The top level holds the FSM, the output stage and the parameter path.

## Test plan
- Ramp image (pixel = addr[7:0]), `busy`=0:
  - first `in_en` 4 cycles after `start`;
  - pixel 16 = value 128 (row 1, `mem_addr` 128);
  - 16384 pixels in total, then `done`.
- Parameter word k = {2'd(k%3), 5'd(k%32), k[0], 16'h1000+k}: at first pixel of LCU 9, `lcu_x`=1, `lcu_y`=1, `ipf_offset`=16'h1009, `ipf_type`=0.
- `busy` high for 3 cycles around pixel 255 of LCU 0: no pixel lost or repeated; side-band switches exactly after pixel 255.
- Random `busy` (50%) over a full frame: output sequence equals the ROM in LCU order.
- `reset` asserted at pixel 5000: all outputs 0. A new `start` then restarts from address 0.
- With `LCU_STREAM_CKSUM_EN`, all-0xFF image: `cksum` = 16384*255 mod 65536 = 16'hC000 at `done`.
